led_display_pattern_gen_param: RTL
==================================

// Module: led_display_pattern_gen_param
// PURPOSE
//  Parametrised test-pattern source for the HUB75-style LED panel path. Emits one dual-half
//  (top/bottom) RGB row per valid/ready transfer with its row address, sweeping all row
//  addresses per frame. Mode changes and effect steps apply only at frame boundaries (no tearing).
//  Adds vertical scan, checkerboard blink, white, frame-done pulse and true stall-safe handshake.
// PARAMETERS
//  SYS_CLK_FREQ   100_000_000  system clock in Hz (informational; effect rate set by EFFECT_CYCLES)
//  SIMULATION     0            1 selects SIM_EFFECT_CYCLES in place of EFFECT_CYCLES
//  NUM_COLS       64           pixels per row (>=4)
//  NUM_ROWS       16           row addresses per frame, per half (power of 2 not required, >=2)
//  EFFECT_CYCLES  1_000_000    clocks per effect tick; SIM_EFFECT_CYCLES = 1000
//  ADDR_W         $clog2(NUM_ROWS) row address width (derived, localparam)
// PORTS
//  clk_in           in   1           system clock, single clock domain
//  n_reset_in       in   1           asynchronous, active-low reset
//  enable_in        in   1           1 = generate rows; 0 = stop at next frame boundary
//  mode_in          in   4           requested mode, sampled only at frame start
//  row_out          out  6*NUM_COLS  {top_r,top_g,top_b,bot_r,bot_g,bot_b}, each NUM_COLS, bit i = column i
//  row_valid_out    out  1           row_out/row_address_out valid
//  row_ready_in     in   1           downstream accepts row
//  row_address_out  out  ADDR_W      row index of row_out
//  frame_done_out   out  1           one-cycle pulse on the transfer of row NUM_ROWS-1
//  active_mode_out  out  4           mode currently being drawn
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, effect pos=0 dir=up phase=0, tick counter 0, pending=0.
//  Modes: 0 OFF, 1 R, 2 G, 3 B, 4 R+G, 5 G+B, 6 R+B, 7 SCAN_H, 8 SCAN_V, 9 CHECKER, 10 WHITE;
//   11..15 draw as OFF. Solid modes fill all columns of both halves in listed colours.
//  SCAN_H: red, only column pos lit, both halves; pos bounces 0..NUM_COLS-1.
//  SCAN_V: green, all columns lit on one line only; pos bounces 0..2*NUM_ROWS-1; pos<NUM_ROWS
//   lights top half at address pos, else bottom half at address pos-NUM_ROWS.
//  CHECKER: R,G,B all set where (col[0]^addr[0]^phase)==1, both halves; phase toggles per step.
//  Bounce: up: pos==MAX -> dir=down,pos=MAX-1 else pos+1; down: pos==0 -> dir=up,pos=1 else pos-1.
//  Tick counter: free-runs 0..EFFECT_CYCLES-1 (wrap); wrap sets pending (saturating: >1 tick/frame = 1 step).
//  FSM IDLE: valid=0; enable_in=1 -> LOAD.
//  FSM LOAD (1 clk): if address==0: active_mode<=mode_in; if mode changed, reset pos/dir/phase and
//   clear pending; else if pending apply one step, clear pending. Then register row -> PRESENT.
//   Row computed from values after that update (new mode/step visible on row 0).
//  FSM PRESENT: valid=1, row_out/address held stable until valid&&ready. On transfer: address+1,
//   wrap NUM_ROWS-1 -> 0 with frame_done_out=1 next cycle; go LOAD, or IDLE if wrapped and enable_in=0.
//  Latency: enable_in rise at clk N -> row 0 valid at N+2; max throughput 1 row per 2 clks.
//  enable_in falling mid-frame: frame completes. mode_in change mid-frame: ignored until row 0.
//  Tick and row-0 LOAD same cycle: tick is counted (pending set) after LOAD consumes -> next frame.
//  Async reset mid-transfer: valid drops immediately; restart at address 0.
// TESTING
//  NUM_COLS=8, NUM_ROWS=4, SIMULATION=1 with SIM_EFFECT_CYCLES=10 unless noted.
//  1 Reset, enable=1, mode=1, ready=1 -> valid at 2nd clk, addresses 0,1,2,3,0; top_r=bot_r=8'hFF,
//    other channels 0; frame_done pulse one cycle after address-3 transfer only.
//  2 ready held 0 for 5 clks in PRESENT at addr 2 -> valid stays 1, row_out/addr constant, no advance.
//  3 mode 1->2 while at address 1 -> rows 1..3 stay red; row 0 of next frame green; active_mode=2.
//  4 mode=7, ready=1 continuously -> top_r column index per frame steps 0,1..7,6..0,1 (one per tick).
//  5 mode=8 -> lit green line walks top addr0..3 then bottom addr0..3, reverses at bottom addr3.
//  6 mode=9 -> row0 top_r=8'hAA, row1 8'h55; after a step row0=8'h55; enable=0 mid-frame -> finishes
//    addr 3 then valid=0; async reset mid-PRESENT -> all outputs 0 in same cycle.

Source files
------------

// File: rtl/led_display_pattern_gen_param.sv
// led_display_pattern_gen_param
//   Test-pattern source for a HUB75-style LED panel. Emits one dual-half
//   (top/bottom) RGB row per valid/ready transfer, sweeping every row address
//   each frame. Mode changes and effect steps only take effect when row 0 is
//   loaded, so a frame is never torn between two patterns.
//
// Ports
//   clk_in           system clock
//   n_reset_in       asynchronous active-low reset
//   enable_in        1 = generate rows; 0 = stop after the current frame
//   mode_in          requested mode, sampled only when row 0 is loaded
//   row_out          {top_r,top_g,top_b,bot_r,bot_g,bot_b}, bit i = column i
//   row_valid_out    row_out / row_address_out valid
//   row_ready_in     downstream accepts the row
//   row_address_out  row index of row_out
//   frame_done_out   one-cycle pulse after the transfer of the last row
//   active_mode_out  mode currently being drawn
//   dbg_state_out    FSM state (0 IDLE, 1 LOAD, 2 PRESENT)
//
// Handshake: a row transfers on a rising clk_in edge where row_valid_out and
// row_ready_in are both 1. While row_valid_out is 1 and no transfer happens,
// row_out and row_address_out hold stable; valid never drops without a
// transfer (except on reset).
module led_display_pattern_gen_param #(
  parameter int SYS_CLK_FREQ      = 100_000_000,
  parameter bit SIMULATION        = 1'b0,
  parameter int NUM_COLS          = 64,
  parameter int NUM_ROWS          = 16,
  parameter int EFFECT_CYCLES     = 1_000_000,
  parameter int SIM_EFFECT_CYCLES = 1000,
  localparam int ADDR_W           = $clog2(NUM_ROWS)
) (
  input  logic                  clk_in,
  input  logic                  n_reset_in,
  input  logic                  enable_in,
  input  logic [3:0]            mode_in,
  output logic [6*NUM_COLS-1:0] row_out,
  output logic                  row_valid_out,
  input  logic                  row_ready_in,
  output logic [ADDR_W-1:0]     row_address_out,
  output logic                  frame_done_out,
  output logic [3:0]            active_mode_out,
  output logic [1:0]            dbg_state_out
);

  localparam int EFF    = SIMULATION ? SIM_EFFECT_CYCLES : EFFECT_CYCLES;
  localparam int TICK_W = (EFF > 1) ? $clog2(EFF) : 1;
  // Effect position must cover both the column sweep and the 2*NUM_ROWS line sweep.
  localparam int SPAN   = (NUM_COLS > 2*NUM_ROWS) ? NUM_COLS : 2*NUM_ROWS;
  localparam int POS_W  = $clog2(SPAN);

  localparam logic [POS_W-1:0]  H_MAX     = POS_W'(NUM_COLS - 1);
  localparam logic [POS_W-1:0]  V_MAX     = POS_W'(2*NUM_ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ROWS - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(EFF - 1);

  localparam logic [3:0] M_R       = 4'd1;
  localparam logic [3:0] M_G       = 4'd2;
  localparam logic [3:0] M_B       = 4'd3;
  localparam logic [3:0] M_RG      = 4'd4;
  localparam logic [3:0] M_GB      = 4'd5;
  localparam logic [3:0] M_RB      = 4'd6;
  localparam logic [3:0] M_SCAN_H  = 4'd7;
  localparam logic [3:0] M_SCAN_V  = 4'd8;
  localparam logic [3:0] M_CHECKER = 4'd9;
  localparam logic [3:0] M_WHITE   = 4'd10;

  if (NUM_COLS < 4 || NUM_ROWS < 2 || EFF < 2 || SYS_CLK_FREQ < 1) begin : g_bad_params
    $error("led_display_pattern_gen_param: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [3:0]            active_mode_q;
  logic [POS_W-1:0]      pos_q;
  logic                  dir_q;      // 0 = counting up, 1 = counting down
  logic                  phase_q;
  logic                  pending_q;  // an effect tick is waiting for the next frame
  logic [TICK_W-1:0]     tick_q;
  logic [6*NUM_COLS-1:0] row_q;
  logic                  valid_q;
  logic                  frame_done_q;

  logic                  tick_wrap;
  logic                  frame_start;
  logic [TICK_W-1:0]     tick_d;
  logic                  pending_d;
  logic [3:0]            mode_d;
  logic [POS_W-1:0]      pos_d;
  logic [POS_W-1:0]      step_max;
  logic                  dir_d;
  logic                  phase_d;
  logic [6*NUM_COLS-1:0] row_d;

  // Frame-boundary update of mode and effect state. Applied only in the
  // row-0 LOAD cycle; the row is then built from these updated values.
  always_comb begin
    tick_wrap   = (tick_q == TICK_LAST);
    tick_d      = tick_wrap ? '0 : tick_q + 1'b1;
    frame_start = (state_q == S_LOAD) && (addr_q == '0);
    // A wrap in the same cycle as the row-0 LOAD survives into the next frame.
    pending_d   = tick_wrap | (pending_q & ~frame_start);
    mode_d      = active_mode_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    phase_d     = phase_q;
    step_max    = (active_mode_q == M_SCAN_H) ? H_MAX : V_MAX;
    if (frame_start) begin
      mode_d = mode_in;
      if (mode_in != active_mode_q) begin
        pos_d   = '0;
        dir_d   = 1'b0;
        phase_d = 1'b0;
      end else if (pending_q) begin
        if (active_mode_q == M_SCAN_H || active_mode_q == M_SCAN_V) begin
          if (!dir_q) begin
            if (pos_q == step_max) begin
              dir_d = 1'b1;
              pos_d = step_max - 1'b1;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = 1'b0;
              pos_d = POS_W'(1);
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
        if (active_mode_q == M_CHECKER) phase_d = ~phase_q;
      end
    end
  end

  logic [NUM_COLS-1:0] tr, tg, tb, br, bg, bb;
  logic [NUM_COLS-1:0] full_c, scan_c, chk_c;
  logic                vline_top, vline_bot;

  always_comb begin
    full_c    = '1;
    scan_c    = {{(NUM_COLS-1){1'b0}}, 1'b1} << pos_d;
    chk_c     = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      chk_c[i] = ((i % 2) == 1) ^ addr_q[0] ^ phase_d;
    end
    vline_top = (int'(pos_d) < NUM_ROWS) && (int'(addr_q) == int'(pos_d));
    vline_bot = (int'(pos_d) >= NUM_ROWS) && (int'(addr_q) + NUM_ROWS == int'(pos_d));
    tr = '0; tg = '0; tb = '0; br = '0; bg = '0; bb = '0;
    case (mode_d)
      M_R:       begin tr = full_c; br = full_c; end
      M_G:       begin tg = full_c; bg = full_c; end
      M_B:       begin tb = full_c; bb = full_c; end
      M_RG:      begin tr = full_c; tg = full_c; br = full_c; bg = full_c; end
      M_GB:      begin tg = full_c; tb = full_c; bg = full_c; bb = full_c; end
      M_RB:      begin tr = full_c; tb = full_c; br = full_c; bb = full_c; end
      M_SCAN_H:  begin tr = scan_c; br = scan_c; end
      M_SCAN_V:  begin
        if (vline_top) tg = full_c;
        if (vline_bot) bg = full_c;
      end
      M_CHECKER: begin
        tr = chk_c; tg = chk_c; tb = chk_c;
        br = chk_c; bg = chk_c; bb = chk_c;
      end
      M_WHITE:   begin
        tr = full_c; tg = full_c; tb = full_c;
        br = full_c; bg = full_c; bb = full_c;
      end
      default:   ;
    endcase
    row_d = {tr, tg, tb, br, bg, bb};
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      active_mode_q <= '0;
      pos_q         <= '0;
      dir_q         <= 1'b0;
      phase_q       <= 1'b0;
      pending_q     <= 1'b0;
      tick_q        <= '0;
      row_q         <= '0;
      valid_q       <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      pending_q    <= pending_d;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable_in) state_q <= S_LOAD;
        end
        S_LOAD: begin
          active_mode_q <= mode_d;
          pos_q         <= pos_d;
          dir_q         <= dir_d;
          phase_q       <= phase_d;
          row_q         <= row_d;
          valid_q       <= 1'b1;
          state_q       <= S_PRESENT;
        end
        S_PRESENT: begin
          if (row_ready_in) begin
            valid_q <= 1'b0;
            if (addr_q == LAST_ADDR) begin
              addr_q       <= '0;
              frame_done_q <= 1'b1;
              state_q      <= enable_in ? S_LOAD : S_IDLE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= S_LOAD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign row_out         = row_q;
  assign row_valid_out   = valid_q;
  assign row_address_out = addr_q;
  assign frame_done_out  = frame_done_q;
  assign active_mode_out = active_mode_q;
  assign dbg_state_out   = state_q;

endmodule
